// File: rtl/posit_decode_arbiter_pkg.sv
// Shared widths and uposit field layout for the posit decode arbiter.
package posit_pkg;
  localparam int POSIT_W    = 8;
  localparam int UPOSIT_W   = 12;
  localparam int NAR_BIT    = 11;
  localparam int ZERO_BIT   = 10;
  localparam int SIGN_BIT   = 9;
  localparam int EXP_MSB    = 8;
  localparam int EXP_LSB    = 5;
  localparam int FRAC_MSB   = 4;
  localparam int FRAC_LSB   = 0;
  localparam int XFER_CNT_W = 16;
endpackage

// File: rtl/posit_decode_8bit.sv
// Combinational posit<8,0> decoder into the unpacked 12-bit uposit form.
module posit_decode_8bit
  import posit_pkg::*;
(
  input  logic [POSIT_W-1:0]  posit_i,
  output logic [UPOSIT_W-1:0] uposit_o
);
  logic [7:0] mag;
  logic [6:0] body, rem;
  logic [3:0] run;
  logic       rbit, done;

  always_comb begin
    uposit_o = '0;
    mag      = posit_i[7] ? (~posit_i + 8'd1) : posit_i;
    body     = mag[6:0];
    rbit     = body[6];
    run      = '0;
    done     = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!done && body[i] == rbit) run = run + 4'd1;
      else done = 1'b1;
    end
    // Drop the regime run and its terminator; what remains is the fraction.
    rem = body << (run + 4'd1);
    if (posit_i == 8'h00) begin
      uposit_o[ZERO_BIT] = 1'b1;
    end else if (posit_i == 8'h80) begin
      uposit_o[NAR_BIT] = 1'b1;
    end else begin
      uposit_o[SIGN_BIT]          = posit_i[7];
      uposit_o[EXP_MSB:EXP_LSB]   = rbit ? (run + 4'd5) : (4'd6 - run);
      uposit_o[FRAC_MSB:FRAC_LSB] = rem[6:2];
    end
  end
endmodule

// File: rtl/posit_decode_arbiter_rr_pick.sv
// Rotating priority encoder: first set bit of elig_i at or above ptr_i, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  logic [IW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    // Walk offsets high to low so the smallest offset from ptr wins.
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (elig_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter sharing one posit decoder among NREQ requesters,
// with a single registered output slot that refills while draining.
module posit_decode_arbiter
  import posit_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_mask,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ-1:0][POSIT_W-1:0]     req_posit,
  output logic [NREQ-1:0]                  req_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [UPOSIT_W-1:0]              out_uposit,
  output logic [IDW-1:0]                   out_id,
  output logic [XFER_CNT_W-1:0]            xfer_count
);
  logic [NREQ-1:0]       elig;
  logic [IDW-1:0]        g, ptr_q, ptr_d, out_id_q, out_id_d;
  logic                  found, can_accept, grant;
  logic                  out_valid_q, out_valid_d;
  logic [UPOSIT_W-1:0]   dec_up, out_uposit_q, out_uposit_d;
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;

  assign elig       = req_valid & req_mask;
  assign can_accept = ~out_valid_q | out_ready;
  assign grant      = found & can_accept & ~rst;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .idx_o  (g),
    .found_o(found)
  );

  posit_decode_8bit u_dec (
    .posit_i (req_posit[g]),
    .uposit_o(dec_up)
  );

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[g] = 1'b1;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_uposit_d = out_uposit_q;
    out_id_d     = out_id_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    if (grant) begin
      out_valid_d  = 1'b1;
      out_uposit_d = dec_up;
      out_id_d     = g;
      ptr_d        = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_uposit_q <= '0;
      out_id_q     <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_uposit_q <= out_uposit_d;
      out_id_q     <= out_id_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_uposit = out_uposit_q;
  assign out_id     = out_id_q;
  assign xfer_count = cnt_q;
endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Scenario bench for posit_decode_arbiter against a value-level posit model.
module tb_posit_decode_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_mask, req_valid, req_ready;
  logic [31:0] req_posit;
  logic        out_valid, out_ready;
  logic [11:0] out_uposit;
  logic [1:0]  out_id;
  logic [15:0] xfer_count;
  int n_cmp = 0, n_fail = 0;

  posit_decode_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_mask(req_mask), .req_valid(req_valid),
    .req_posit(req_posit), .req_ready(req_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_uposit(out_uposit), .out_id(out_id),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // posit<8,0>: value = (-1)^s * 2^k * 1.f, reported with exponent bias 6.
  function automatic logic [11:0] ref_decode(input logic [7:0] p);
    logic [7:0] m;
    logic       r;
    int run, k, nrem, f;
    if (p == 8'h00) return 12'h400;
    if (p == 8'h80) return 12'h800;
    m = p[7] ? 8'(-p) : p;
    r = m[6];
    run = 0;
    while (run < 7 && m[6-run] == r) run++;
    k = r ? run - 1 : -run;
    nrem = 6 - run;
    if (nrem < 0) nrem = 0;
    f = int'(m) & ((1 << nrem) - 1);
    return {2'b00, p[7], 4'(k + 6), 5'(f << (5 - nrem))};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_mask = 4'hF; req_valid = 4'hF; req_posit = 32'h12345678; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_uposit !== 12'h000 || out_id !== 2'd0) begin n_fail++; $display("FAIL reset_data: got %h/%0d want 000/0", out_uposit, out_id); end
    n_cmp++; if (xfer_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", xfer_count); end
    rst = 1'b0; req_valid = 4'h0;
  endtask

  task automatic test_single();
    req_mask = 4'hF; out_ready = 1'b1;
    req_valid = 4'b0001; req_posit[7:0] = 8'h76; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    tick(); req_valid = 4'b0000;
    n_cmp++; if (out_valid !== 1'b1 || out_uposit !== 12'h118 || out_id !== 2'd0) begin n_fail++; $display("FAIL single_out: got v%b %h id%0d want v1 118 id0", out_valid, out_uposit, out_id); end
    n_cmp++; if (xfer_count !== 16'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", xfer_count); end
    req_valid = 4'b0100; req_posit[23:16] = 8'h8a;
    tick(); req_valid = 4'b0000;
    n_cmp++; if (out_uposit !== 12'h318 || out_id !== 2'd2) begin n_fail++; $display("FAIL single_neg: got %h id%0d want 318 id2", out_uposit, out_id); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [7:0] p [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin p[i] = 8'($urandom); req_posit[8*i +: 8] = p[i]; end
    req_mask = 4'hF; req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      tick();
      n_cmp++; if (out_id !== 2'(c % 4) || out_uposit !== ref_decode(p[c%4])) begin n_fail++; $display("FAIL rr_out[%0d]: got %h id%0d want %h id%0d", c, out_uposit, out_id, ref_decode(p[c%4]), c % 4); end
      p[c%4] = 8'($urandom); req_posit[8*(c%4) +: 8] = p[c%4];
    end
    req_valid = 4'h0;
  endtask

  task automatic test_backpressure();
    logic [7:0] p2;
    req_valid = 4'b0010; req_posit[15:8] = 8'ha9; out_ready = 1'b1;
    tick();
    p2 = 8'($urandom); req_posit[23:16] = p2; req_valid = 4'b0100; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_uposit !== ref_decode(8'ha9) || out_id !== 2'd1) begin n_fail++; $display("FAIL bp_hold[%0d]: got v%b %h id%0d want v1 %h id1", c, out_valid, out_uposit, out_id, ref_decode(8'ha9)); end
    end
    out_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if (out_valid !== 1'b1 || out_uposit !== ref_decode(p2) || out_id !== 2'd2) begin n_fail++; $display("FAIL bp_swap: got v%b %h id%0d want v1 %h id2", out_valid, out_uposit, out_id, ref_decode(p2)); end
  endtask

  task automatic test_mask();
    int exp_id [4] = '{0, 2, 0, 2};
    req_mask = 4'b0101; req_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (out_id !== 2'(exp_id[c]) || out_valid !== 1'b1) begin n_fail++; $display("FAIL mask_id[%0d]: got v%b id%0d want v1 id%0d", c, out_valid, out_id, exp_id[c]); end
    end
    req_mask = 4'b0000; #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mask_zero_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mask_zero_drain: got %b want 0", out_valid); end
    req_mask = 4'hF; req_valid = 4'h0;
  endtask

  task automatic test_reset_midstall();
    req_valid = 4'b0010; out_ready = 1'b1;
    tick();
    req_valid = 4'hF; out_ready = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midstall_pre: got %b want 1", out_valid); end
    do_reset();
    n_cmp++; if (out_valid !== 1'b0 || xfer_count !== 16'd0) begin n_fail++; $display("FAIL midstall_reset: got v%b cnt%0d want v0 cnt0", out_valid, xfer_count); end
    out_ready = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midstall_ready: got %b want 0001", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL midstall_id: got %0d want 0", out_id); end
  endtask

  task automatic test_random();
    logic        m_valid = 1'b0;
    logic [11:0] m_up = '0;
    int m_id = 0, m_ptr = 0, m_cnt = 0, exp_g;
    logic [3:0]  exp_rdy;
    logic [7:0]  pg;
    do_reset();
    req_valid = 4'h0; req_mask = 4'hF;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          req_valid[i] = 1'b1;
          case ($urandom_range(9))
            0: req_posit[8*i +: 8] = 8'h00;
            1: req_posit[8*i +: 8] = 8'h80;
            default: req_posit[8*i +: 8] = 8'($urandom);
          endcase
        end
      if ($urandom_range(7) == 0) req_mask = 4'($urandom);
      out_ready = ($urandom_range(3) != 0);
      #1;
      exp_g = -1;
      if (!m_valid || out_ready)
        for (int s = 0; s < 4; s++) begin
          int j = (m_ptr + s) % 4;
          if (exp_g < 0 && req_valid[j] && req_mask[j]) exp_g = j;
        end
      exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0000;
      n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      pg = (exp_g >= 0) ? req_posit[8*exp_g +: 8] : 8'h00;
      tick();
      if (exp_g >= 0) begin
        m_valid = 1'b1; m_up = ref_decode(pg); m_id = exp_g; m_ptr = (exp_g + 1) % 4;
        if (m_cnt < 65535) m_cnt++;
        req_valid[exp_g] = 1'b0;
      end else if (out_ready) m_valid = 1'b0;
      n_cmp++; if (out_valid !== m_valid || xfer_count !== 16'(m_cnt)) begin n_fail++; $display("FAIL rand_state[%0d]: got v%b cnt%0d want v%b cnt%0d", c, out_valid, xfer_count, m_valid, m_cnt); end
      if (m_valid) begin
        n_cmp++; if (out_uposit !== m_up || out_id !== 2'(m_id)) begin n_fail++; $display("FAIL rand_out[%0d]: got %h id%0d want %h id%0d", c, out_uposit, out_id, m_up, m_id); end
      end
    end
    req_valid = 4'h0;
  endtask

  task automatic test_saturation();
    int exp_c;
    do_reset();
    req_mask = 4'hF; req_valid = 4'b0001; req_posit[7:0] = 8'h40; out_ready = 1'b1;
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 65534 || n == 65535 || n == 65536 || n == 65540) begin
        exp_c = (n > 65535) ? 65535 : n;
        n_cmp++; if (xfer_count !== 16'(exp_c)) begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", n, xfer_count, exp_c); end
      end
    end
    req_valid = 4'h0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_midstall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
